// File: rtl/sram_test_pkg.sv
// Shared FSM state encoding and March C- element table for the SRAM tester.
// Definitions only: no latency and no flow control.
package sram_test_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_M0    = 4'd1,
    ST_M1    = 4'd2,
    ST_M2    = 4'd3,
    ST_M3    = 4'd4,
    ST_M4    = 4'd5,
    ST_M5    = 4'd6,
    ST_DRAIN = 4'd7,
    ST_DONE  = 4'd8
  } state_e;

  // One bit per element index (bit n = element Mn); indices 6 and 7 are unused.
  localparam logic [7:0] MARCH_DOWN   = 8'b0001_1000;
  localparam logic [7:0] MARCH_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] MARCH_RD_ONE = 8'b0001_0100;
  localparam logic [7:0] MARCH_HAS_WR = 8'b0001_1111;
  localparam logic [7:0] MARCH_WR_ONE = 8'b0000_1010;

  typedef struct packed {
    logic has_rd;
    logic rd_one;
    logic has_wr;
    logic wr_one;
  } march_op_t;

  function automatic march_op_t march_op(input logic [2:0] idx);
    march_op_t e;
    e.has_rd = MARCH_HAS_RD[idx];
    e.rd_one = MARCH_RD_ONE[idx];
    e.has_wr = MARCH_HAS_WR[idx];
    e.wr_one = MARCH_WR_ONE[idx];
    return e;
  endfunction

  function automatic logic march_dir(input logic [2:0] idx);
    return MARCH_DOWN[idx];
  endfunction

endpackage

// File: rtl/sram_march_addr_gen.sv
// Address sequencer for one March element: load latches direction and start address.
// Registered address, one step per cycle; no backpressure.
module sram_march_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;

  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    if (load) begin
      dir_d  = dir;
      addr_d = dir ? '1 : '0;
    end else if (step) begin
      addr_d = dir_q ? (addr_q - ONE) : (addr_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
    end
  end

  // Direction is latched so last never depends on the load decision it drives.
  assign addr = addr_q;
  assign last = dir_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_march_tester.sv
// March C- SRAM BIST with manual access port; one SRAM op per cycle, done 10*DEPTH+2 cycles after start.
// Optional first-fail log under SRAM_TEST_FAIL_LOG_EN; no backpressure, SRAM assumed always ready.
module sram_march_tester
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              man_en,
  input  logic              man_wen,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_din,
  output logic [DATA_W-1:0] man_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              mem_men,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef SRAM_TEST_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              fail_vld
`endif
);

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] man_dout_q, man_dout_d;
  logic              man_rd_q, man_rd_d;
  logic              chk_vld_q, chk_vld_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;

  logic              in_test;
  logic [2:0]        elem_idx;
  march_op_t         cur;
  logic              two_op;
  logic              op_rd;
  logic              op_wr;
  logic              addr_done;
  logic              elem_end;
  logic              start_go;
  logic              man_go;
  logic              mis;
  logic              ag_load;
  logic              ag_dir;
  logic              ag_last;
  logic [ADDR_W-1:0] ag_addr;

  assign in_test  = (state_q >= ST_M0) && (state_q <= ST_M5);
  assign elem_idx = state_q[2:0] - 3'd1;
  assign cur      = march_op(elem_idx);
  assign two_op   = cur.has_rd & cur.has_wr;

  // Two-op elements alternate read (phase 0) and write (phase 1) at each address.
  assign op_rd     = in_test & cur.has_rd & ~phase_q;
  assign op_wr     = in_test & cur.has_wr & (~cur.has_rd | phase_q);
  assign addr_done = in_test & (~two_op | phase_q);
  assign elem_end  = addr_done & ag_last;

  assign start_go = (state_q == ST_IDLE) & start;
  assign man_go   = (state_q == ST_IDLE) & man_en & ~start;
  assign mis      = chk_vld_q & (mem_dout != chk_exp_q);

  assign ag_load = start_go | elem_end;
  assign ag_dir  = start_go ? march_dir(3'd0) : march_dir(elem_idx + 3'd1);

  sram_march_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (ag_load),
    .dir  (ag_dir),
    .step (addr_done),
    .addr (ag_addr),
    .last (ag_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_M0;
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5:
                if (elem_end) state_d = state_e'(state_q + 4'd1);
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phase_d    = (in_test & two_op) ? ~phase_q : 1'b0;
    chk_vld_d  = op_rd;
    chk_exp_d  = {DATA_W{cur.rd_one}};
    man_rd_d   = man_go & ~man_wen;
    man_dout_d = man_rd_q ? mem_dout : man_dout_q;
    err_d      = err_q;
    if (start_go) begin
      err_d = '0;
    end else if (mis && (err_q != '1)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      err_q      <= '0;
      man_dout_q <= '0;
      man_rd_q   <= 1'b0;
      chk_vld_q  <= 1'b0;
      chk_exp_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
      man_dout_q <= man_dout_d;
      man_rd_q   <= man_rd_d;
      chk_vld_q  <= chk_vld_d;
      chk_exp_q  <= chk_exp_d;
    end
  end

`ifdef SRAM_TEST_FAIL_LOG_EN
  logic [ADDR_W-1:0] chk_addr_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_exp_q;
  logic [DATA_W-1:0] fail_got_q;
  logic              fail_vld_q;

  // Only the first mismatch of a run is kept; later ones leave the log alone.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      chk_addr_q  <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      fail_vld_q  <= 1'b0;
    end else begin
      chk_addr_q <= ag_addr;
      if (mis && !fail_vld_q) begin
        fail_addr_q <= chk_addr_q;
        fail_exp_q  <= chk_exp_q;
        fail_got_q  <= mem_dout;
        fail_vld_q  <= 1'b1;
      end
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;
  assign fail_vld  = fail_vld_q;
`endif

  // Strobes are gated by rst so an aborted run issues nothing in the reset cycle.
  assign mem_men  = ~rst & (op_rd | op_wr | man_go);
  assign mem_wen  = ~rst & (op_wr | (man_go & man_wen));
  assign mem_ren  = ~rst & (op_rd | (man_go & ~man_wen));
  assign mem_addr = man_go ? man_addr : ag_addr;
  assign mem_din  = man_go ? man_din : {DATA_W{cur.wr_one}};

  assign busy     = in_test | (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign pass     = ~busy & (err_q == '0);
  assign err_cnt  = err_q;
  assign man_dout = man_dout_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester: ADDR_W=4 DUT with a faultable SRAM model, plus an ERR_W=2 DUT on an all-zero SRAM.
// Expected op stream and error counts come from a March C- model built from the element list.
module tb_sram_march_tester;

  localparam int D    = 16;
  localparam int NOPS = 10 * D;

  logic       clk, rst, start, man_en, man_wen;
  logic [3:0] man_addr;
  logic [7:0] man_din, man_dout;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic       mem_men, mem_wen, mem_ren;
  logic [3:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
`ifdef SRAM_TEST_FAIL_LOG_EN
  logic [3:0] fail_addr;
  logic [7:0] fail_exp, fail_got;
  logic       fail_vld;
  logic [3:0] fail_addr_s;
  logic [7:0] fail_exp_s, fail_got_s;
  logic       fail_vld_s;
`endif

  logic       man_en_s, man_wen_s;
  logic [3:0] man_addr_s;
  logic [7:0] man_din_s, man_dout_s;
  logic       busy_s, done_s, pass_s;
  logic [1:0] err_cnt_s;
  logic       mem_men_s, mem_wen_s, mem_ren_s;
  logic [3:0] mem_addr_s;
  logic [7:0] mem_din_s, mem_dout_s;

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .man_en(man_en), .man_wen(man_wen),
    .man_addr(man_addr), .man_din(man_din), .man_dout(man_dout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .mem_men(mem_men), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef SRAM_TEST_FAIL_LOG_EN
    , .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got), .fail_vld(fail_vld)
`endif
  );

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .man_en(man_en_s), .man_wen(man_wen_s),
    .man_addr(man_addr_s), .man_din(man_din_s), .man_dout(man_dout_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .mem_men(mem_men_s), .mem_wen(mem_wen_s), .mem_ren(mem_ren_s),
    .mem_addr(mem_addr_s), .mem_din(mem_din_s), .mem_dout(mem_dout_s)
`ifdef SRAM_TEST_FAIL_LOG_EN
    , .fail_addr(fail_addr_s), .fail_exp(fail_exp_s), .fail_got(fail_got_s), .fail_vld(fail_vld_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model with an optional stuck-at-1 mask on one address.
  logic [7:0] sram [16];
  logic [7:0] rdata;
  logic       stuck_en;
  logic [3:0] stuck_addr;
  logic [7:0] stuck_mask;

  always @(posedge clk) begin
    if (mem_men) begin
      if (mem_wen) sram[mem_addr] <= mem_din;
      if (mem_ren) rdata <= sram[mem_addr] | ((stuck_en && mem_addr == stuck_addr) ? stuck_mask : 8'h00);
    end
  end
  assign mem_dout = rdata;

  assign man_en_s   = 1'b0;
  assign man_wen_s  = 1'b0;
  assign man_addr_s = 4'h0;
  assign man_din_s  = 8'h00;
  assign mem_dout_s = 8'h00;

  int vec  = 0;
  int miss = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // March C- model: element list expanded into the exact per-cycle op stream.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
  } op_t;

  op_t        ops[$];
  bit         mrun;
  int         mcyc;
  int         exp_err;
  logic [7:0] mmem [16];
  bit         mf_vld;
  logic [3:0] mf_addr;
  logic [7:0] mf_exp, mf_got;
  logic [7:0] exp_man_dout;
  op_t        cur_op;
  logic [7:0] rd_got;

  task automatic build_ops();
    bit e_dn [6] = '{0, 0, 0, 1, 1, 0};
    bit e_rd [6] = '{0, 1, 1, 1, 1, 1};
    bit e_rv [6] = '{0, 0, 1, 0, 1, 0};
    bit e_wr [6] = '{1, 1, 1, 1, 1, 0};
    bit e_wv [6] = '{0, 1, 0, 1, 0, 0};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < D; i++) begin
        o.a = e_dn[e] ? 4'(D - 1 - i) : 4'(i);
        if (e_rd[e]) begin
          o.rd = 1'b1; o.wr = 1'b0; o.d = e_rv[e] ? 8'hFF : 8'h00;
          ops.push_back(o);
        end
        if (e_wr[e]) begin
          o.rd = 1'b0; o.wr = 1'b1; o.d = e_wv[e] ? 8'hFF : 8'h00;
          ops.push_back(o);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mrun) begin
      mcyc++;
      if (mcyc <= NOPS) begin
        cur_op = ops[mcyc-1];
        check("op_men", mem_men, 1);
        check("op_wen", mem_wen, cur_op.wr);
        check("op_ren", mem_ren, cur_op.rd);
        check("op_addr", mem_addr, cur_op.a);
        check("s_op_ren", mem_ren_s, cur_op.rd);
        check("s_op_addr", mem_addr_s, cur_op.a);
        if (cur_op.wr) begin
          check("op_din", mem_din, cur_op.d);
          mmem[cur_op.a] = cur_op.d;
        end
        if (cur_op.rd) begin
          rd_got = mmem[cur_op.a] | ((stuck_en && cur_op.a == stuck_addr) ? stuck_mask : 8'h00);
          if (rd_got != cur_op.d) begin
            if (exp_err < 255) exp_err++;
            if (!mf_vld) begin
              mf_vld = 1'b1; mf_addr = cur_op.a; mf_exp = cur_op.d; mf_got = rd_got;
            end
          end
        end
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_pass", pass, 0);
      end else if (mcyc == NOPS + 1) begin
        check("drain_men", mem_men, 0);
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
      end else if (mcyc == NOPS + 2) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_err", err_cnt, exp_err);
        check("done_pass", pass, (exp_err == 0));
        check("sat_done", done_s, 1);
        check("sat_err", err_cnt_s, 2'd3);
        check("sat_pass", pass_s, 0);
`ifdef SRAM_TEST_FAIL_LOG_EN
        check("flog_vld", fail_vld, mf_vld);
        if (mf_vld) begin
          check("flog_addr", fail_addr, mf_addr);
          check("flog_exp", fail_exp, mf_exp);
          check("flog_got", fail_got, mf_got);
        end
`endif
      end else begin
        check("post_done", done, 0);
        check("post_err", err_cnt, exp_err);
        check("post_pass", pass, (exp_err == 0));
        mrun = 1'b0;
      end
      check("run_man_dout", man_dout, exp_man_dout);
    end
  end

  task automatic do_start(input bit with_man);
    @(posedge clk); #1;
    start = 1'b1;
    if (with_man) begin
      man_en = 1'b1; man_wen = 1'b1; man_addr = 4'd7; man_din = 8'h3C;
    end
    @(negedge clk);
    check("start_no_man", mem_men, 0);
    @(posedge clk); #1;
    start = 1'b0; man_en = 1'b0; man_wen = 1'b0;
    build_ops();
    mcyc = 0; exp_err = 0; mf_vld = 1'b0;
    mrun = 1'b1;
  endtask

  task automatic wait_run();
    int n = 0;
    while (mrun && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("run_timeout", {31'b0, mrun}, 0);
    mrun = 1'b0;
    @(negedge clk);
  endtask

  bit quiet;

  initial begin
    rst = 1'b1; start = 1'b0; man_en = 1'b0; man_wen = 1'b0;
    man_addr = 4'h0; man_din = 8'h00;
    stuck_en = 1'b0; stuck_addr = 4'd5; stuck_mask = 8'h04;
    exp_man_dout = 8'h00; mrun = 1'b0; mcyc = 0; exp_err = 0; mf_vld = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cnt, 0);
    check("rst_pass", pass, 1);
    check("rst_man_dout", man_dout, 0);
    check("rst_men", mem_men, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_s_err", err_cnt_s, 0);
    check("rst_s_man_dout", man_dout_s, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Manual write 0xA5 to address 3, then read it back.
    man_en = 1'b1; man_wen = 1'b1; man_addr = 4'd3; man_din = 8'hA5;
    @(negedge clk);
    check("man_w_men", mem_men, 1);
    check("man_w_wen", mem_wen, 1);
    check("man_w_ren", mem_ren, 0);
    check("man_w_addr", mem_addr, 3);
    check("man_w_din", mem_din, 8'hA5);
    @(posedge clk); #1;
    man_wen = 1'b0; man_din = 8'h00;
    @(negedge clk);
    check("man_r_wen", mem_wen, 0);
    check("man_r_ren", mem_ren, 1);
    check("man_r_addr", mem_addr, 3);
    @(posedge clk); #1;
    man_en = 1'b0;
    @(negedge clk);
    check("man_idle_men", mem_men, 0);
    @(negedge clk);
    check("man_dout", man_dout, 8'hA5);
    exp_man_dout = 8'hA5;

    // Clean run, start presented together with a manual write.
    do_start(1'b1);
    wait_run();
    check("clean_err", err_cnt, 0);
    check("clean_pass", pass, 1);

    // Stuck-at-1 on bit 2 of address 5, with start/man_en poked mid-run.
    stuck_en = 1'b1;
    do_start(1'b0);
    repeat (29) @(posedge clk);
    #1;
    start = 1'b1; man_en = 1'b1; man_wen = 1'b1; man_addr = 4'd9; man_din = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    man_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; man_en = 1'b0;
    wait_run();
    check("stuck_err", err_cnt, 3);
    check("stuck_pass", pass, 0);
`ifdef SRAM_TEST_FAIL_LOG_EN
    check("stuck_faddr", fail_addr, 5);
    check("stuck_fexp", fail_exp, 8'h00);
    check("stuck_fgot", fail_got, 8'h04);
    check("stuck_fvld", fail_vld, 1);
`endif

    // A fresh start must clear the previous error count.
    stuck_en = 1'b0;
    do_start(1'b0);
    wait_run();
    check("reclean_err", err_cnt, 0);
    check("reclean_pass", pass, 1);
`ifdef SRAM_TEST_FAIL_LOG_EN
    check("reclean_fvld", fail_vld, 0);
`endif

    // Reset during cycle 50 of a run.
    do_start(1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    mrun = 1'b0;
    @(negedge clk);
    check("abort_men", mem_men, 0);
    check("abort_wen", mem_wen, 0);
    check("abort_ren", mem_ren, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_err", err_cnt, 0);
    check("abort_pass", pass, 1);
    check("abort_man_dout", man_dout, 0);
    exp_man_dout = 8'h00;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done || busy || mem_men || mem_wen || mem_ren || done_s || busy_s) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1);

    do_start(1'b0);
    wait_run();
    check("post_abort_err", err_cnt, 0);
    check("post_abort_pass", pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
